router_reg: RTL and testbench
=============================

// Module: router_reg
// PURPOSE
//  Datapath register block of the packet router, between the input FSM and the
//  output FIFOs. Latches the header byte and forwards header/payload/parity
//  bytes to dout under FSM state strobes. Holds a byte that arrives while the
//  FIFO is full. Computes running XOR parity, flags an end-of-packet with
//  pkt_valid low, and reports a parity mismatch.
// PARAMETERS
//  DW  8  byte width of data_in/dout; header layout fixed: [7:2]=payload length, [1:0]=address
// PORTS
//  clock          in   1   single clock; all registers update on its rising edge
//  resetn         in   1   asynchronous, active-low reset
//  pkt_valid      in   1   source byte valid; falls together with the parity byte
//  fifo_full      in   1   destination FIFO full
//  rst_int_reg    in   1   clears low_pkt_valid
//  detect_add     in   1   FSM DECODE_ADDRESS state
//  ld_state       in   1   FSM LOAD_DATA state
//  laf_state      in   1   FSM LOAD_AFTER_FULL state
//  full_state     in   1   FSM FIFO_FULL_STATE
//  lfd_state      in   1   FSM LOAD_FIRST_DATA (header write) state
//  data_in        in   DW  incoming byte
//  parity_done    out  1   packet parity byte has been captured
//  err            out  1   internal parity != received parity
//  low_pkt_valid  out  1   pkt_valid dropped while loading (packet end seen)
//  dout           out  DW  byte to FIFO
// BEHAVIOUR
//  All registers reset to 0 asynchronously: dout, parity_done, err, low_pkt_valid,
//  plus internal hdr_byte, ffull_byte, int_parity, pkt_parity.
//  Register updates on each rising edge. Where several conditions are listed,
//  the first true one applies (priority order).
//  hdr_byte: if detect_add & pkt_valid & data_in[1:0]!=2'b11, hdr_byte<=data_in.
//  dout, priority:
//    lfd_state -> hdr_byte; ld_state&!fifo_full -> data_in; laf_state -> ffull_byte;
//    else hold.
//  ffull_byte: ld_state & fifo_full -> data_in (dout holds).
//  low_pkt_valid: rst_int_reg -> 0; ld_state & !pkt_valid -> 1; else hold.
//  parity_done: detect_add -> 0;
//    (ld_state&!fifo_full&!pkt_valid) | (laf_state&low_pkt_valid&!parity_done) -> 1;
//    else hold.
//  int_parity: detect_add -> 0; lfd_state&pkt_valid -> int_parity^hdr_byte;
//    ld_state&pkt_valid&!full_state -> int_parity^data_in; else hold.
//  pkt_parity: detect_add -> 0; ld_state&!pkt_valid -> data_in; else hold.
//  err: detect_add -> 0; parity_done -> (int_parity!=pkt_parity); else hold.
//    err is valid one cycle after parity_done rises.
//  detect_add has priority over lfd_state in the same cycle. The header is
//    latched at that edge and XORed into parity on the next lfd_state edge.
//  Latency: every byte reaches dout 1 clock after its qualifying strobe.
//  Address 2'b11 is invalid: header not latched.
//  Reset mid-packet clears all state immediately, regardless of the clock.
// STRUCTURE
//  Single flat module, no sub-modules. DW and the header field positions
//  (LEN=[7:2], ADDR=[1:0], ADDR_INVALID=2'b11) go in the shared router package.
//  The package is shared with the FSM and FIFO.
// TESTING
//  1 reset: resetn=0 mid-cycle -> all outputs 0 at once, no clock edge needed.
//  2 good pkt: header 8'h49 (len 18, addr 1) with detect_add&lfd&pkt_valid, then
//    lfd, then 18 random bytes under ld_state, then correct XOR byte with pkt_valid=0.
//    Required: dout=8'h49 then each byte, 1 clk late; low_pkt_valid=1 and
//    parity_done=1 after the parity edge; err=0.
//  3 bad parity: same packet, final byte = correct^8'h01 -> err=1 one cycle after parity_done.
//  4 fifo_full: ld_state&fifo_full with data_in=8'hA5 -> dout holds;
//    then laf_state -> dout=8'hA5.
//  5 invalid addr: detect_add&pkt_valid with data_in=8'h4B -> hdr_byte unchanged;
//    next lfd_state drives the old header to dout.
//  6 rst_int_reg=1 after packet end -> low_pkt_valid=0; next detect_add clears parity_done and err.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: byte width and header field layout shared by the router FSM, FIFO and register block
package router_pkg;
    localparam int            DW           = 8;
    localparam int            LEN_MSB      = 7;
    localparam int            LEN_LSB      = 2;
    localparam int            ADDR_MSB     = 1;
    localparam int            ADDR_LSB     = 0;
    localparam logic [1:0]    ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_reg.sv
// router_reg: header latch, byte forwarding to the FIFO, full-hold byte and running XOR parity check
module router_reg
    import router_pkg::*;
#(
    parameter int DW = router_pkg::DW
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          pkt_valid,
    input  logic          fifo_full,
    input  logic          rst_int_reg,
    input  logic          detect_add,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          lfd_state,
    input  logic [DW-1:0] data_in,
    output logic          parity_done,
    output logic          err,
    output logic          low_pkt_valid,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] hdr_q, hdr_d, ffull_q, ffull_d, int_par_q, int_par_d, pkt_par_q, pkt_par_d, dout_q, dout_d;
    logic          pd_q, pd_d, err_q, err_d, lpv_q, lpv_d;
    logic          hdr_ok, ld_go;

    assign hdr_ok = detect_add && pkt_valid && (data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID);
    assign ld_go  = ld_state && !fifo_full;

    // next-state for every register; detect_add clears the per-packet parity state first
    always_comb begin
        hdr_d     = hdr_ok ? data_in : hdr_q;
        dout_d    = lfd_state ? hdr_q : ld_go ? data_in : laf_state ? ffull_q : dout_q;
        ffull_d   = (ld_state && fifo_full) ? data_in : ffull_q;
        lpv_d     = rst_int_reg ? 1'b0 : (ld_state && !pkt_valid) ? 1'b1 : lpv_q;
        pd_d      = detect_add ? 1'b0 :
                    ((ld_go && !pkt_valid) || (laf_state && lpv_q && !pd_q)) ? 1'b1 : pd_q;
        int_par_d = detect_add ? '0 :
                    (lfd_state && pkt_valid) ? (int_par_q ^ hdr_q) :
                    (ld_state && pkt_valid && !full_state) ? (int_par_q ^ data_in) : int_par_q;
        pkt_par_d = detect_add ? '0 : (ld_state && !pkt_valid) ? data_in : pkt_par_q;
        err_d     = detect_add ? 1'b0 : pd_q ? (int_par_q != pkt_par_q) : err_q;
    end

    // state registers, cleared asynchronously so a mid-packet reset takes effect at once
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q     <= '0;
            dout_q    <= '0;
            ffull_q   <= '0;
            lpv_q     <= 1'b0;
            pd_q      <= 1'b0;
            int_par_q <= '0;
            pkt_par_q <= '0;
            err_q     <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            dout_q    <= dout_d;
            ffull_q   <= ffull_d;
            lpv_q     <= lpv_d;
            pd_q      <= pd_d;
            int_par_q <= int_par_d;
            pkt_par_q <= pkt_par_d;
            err_q     <= err_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = pd_q;
    assign err           = err_q;
    assign low_pkt_valid = lpv_q;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed checks of header latch, forwarding latency, parity, full hold and reset
module tb_router_reg;
    logic       clock = 1'b0, resetn = 1'b0;
    logic       pkt_valid = 1'b0, fifo_full = 1'b0, rst_int_reg = 1'b0, detect_add = 1'b0;
    logic       ld_state = 1'b0, laf_state = 1'b0, full_state = 1'b0, lfd_state = 1'b0;
    logic [7:0] data_in = '0, dout;
    logic       parity_done, err, low_pkt_valid;
    int         checks = 0, errors = 0;
    logic [7:0] pl [18] = '{8'h3C, 8'hF1, 8'h07, 8'h9A, 8'h55, 8'hE2, 8'h10, 8'h6D, 8'hB8,
                            8'h2F, 8'hC4, 8'h81, 8'h7E, 8'h03, 8'hD9, 8'h46, 8'hAA, 8'h1B};

    router_reg dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
        .data_in(data_in), .parity_done(parity_done), .err(err),
        .low_pkt_valid(low_pkt_valid), .dout(dout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        {pkt_valid, fifo_full, rst_int_reg, detect_add, ld_state, laf_state, full_state, lfd_state} = '0;
        data_in = '0;
    endtask

    // full packet: header 8'h49, 18 payload bytes, parity byte XORed with flip
    task automatic send_pkt(input logic [7:0] flip);
        logic [7:0] par;
        par = 8'h49;
        idle();
        detect_add = 1'b1; lfd_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h49;
        step();
        detect_add = 1'b0;
        step();
        check("hdr_dout", dout, 8'h49);
        lfd_state = 1'b0; ld_state = 1'b1;
        for (int i = 0; i < 18; i++) begin
            data_in = pl[i];
            par ^= pl[i];
            step();
            check($sformatf("pl_dout%0d", i), dout, pl[i]);
        end
        pkt_valid = 1'b0; data_in = par ^ flip;
        step();
        check("par_dout", dout, par ^ flip);
        check("lpv_set", low_pkt_valid, 1);
        check("pd_set", parity_done, 1);
        check("err_pre", err, 0);
        idle();
        step();
        check("err_post", err, (flip != 0) ? 1 : 0);
    endtask

    initial begin
        step();
        step();
        check("rst_dout", dout, 0);
        check("rst_pd", parity_done, 0);
        check("rst_err", err, 0);
        check("rst_lpv", low_pkt_valid, 0);
        resetn = 1'b1;
        step();
        send_pkt(8'h00);
        send_pkt(8'h01);
        // FIFO full: dout holds, byte is replayed under laf_state
        ld_state = 1'b1; fifo_full = 1'b1; full_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hA5;
        step();
        check("full_hold", dout, 8'h49 ^ 8'h01 ^ pl[0] ^ pl[1] ^ pl[2] ^ pl[3] ^ pl[4] ^ pl[5]
              ^ pl[6] ^ pl[7] ^ pl[8] ^ pl[9] ^ pl[10] ^ pl[11] ^ pl[12] ^ pl[13] ^ pl[14]
              ^ pl[15] ^ pl[16] ^ pl[17]);
        idle();
        laf_state = 1'b1;
        step();
        check("laf_dout", dout, 8'hA5);
        idle();
        rst_int_reg = 1'b1;
        step();
        check("rst_int_lpv", low_pkt_valid, 0);
        check("pd_hold", parity_done, 1);
        check("err_hold", err, 1);
        // invalid address: header kept, detect_add clears parity_done and err
        idle();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h4B;
        step();
        check("da_pd_clr", parity_done, 0);
        check("da_err_clr", err, 0);
        idle();
        lfd_state = 1'b1; pkt_valid = 1'b1;
        step();
        check("bad_addr_hdr", dout, 8'h49);
        // mid-packet reset clears everything without a clock edge
        idle();
        ld_state = 1'b1; data_in = 8'h77;
        step();
        check("mid_lpv", low_pkt_valid, 1);
        check("mid_pd", parity_done, 1);
        idle();
        #2 resetn = 1'b0;
        #1;
        check("async_dout", dout, 0);
        check("async_pd", parity_done, 0);
        check("async_lpv", low_pkt_valid, 0);
        check("async_err", err, 0);
        resetn = 1'b1;
        lfd_state = 1'b1;
        step();
        check("async_hdr", dout, 0);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
